// File: rtl/stack_ptr_unit.sv
// Registered descending stack pointer with a push/pop/load request-ack handshake,
// stack address generation and sticky wrap flags. Define STACK_PTR_LIMIT_EN to block wrapping.
module stack_ptr_unit #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_SP = WIDTH'(8'hFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] addr,
    output logic             addr_valid,
    output logic             ack,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sp_q, sp_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             addr_valid_q, addr_valid_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [XW-1:0]    inc_sum_c;
    logic [XW-1:0]    dec_sum_c;
    logic [WIDTH-1:0] inc_res_c;
    logic [WIDTH-1:0] dec_res_c;
    logic             inc_carry_c;
    logic             dec_borrow_c;
    logic             empty_c;
    logic             full_c;
    logic             push_blk_c;
    logic             pop_blk_c;
    logic             push_only_c;
    logic             pop_only_c;
    logic             replace_c;

    // Shared increment/decrement datapath; the extra MSB carries carry/borrow out.
    assign inc_sum_c    = {1'b0, sp_q} + XW'(1);
    assign dec_sum_c    = {1'b0, sp_q} - XW'(1);
    assign inc_res_c    = inc_sum_c[WIDTH-1:0];
    assign dec_res_c    = dec_sum_c[WIDTH-1:0];
    assign inc_carry_c  = inc_sum_c[WIDTH];
    assign dec_borrow_c = dec_sum_c[WIDTH];

    assign empty_c = (sp_q == RESET_SP);
    assign full_c  = (sp_q == '0);

`ifdef STACK_PTR_LIMIT_EN
    assign push_blk_c = full_c;
    assign pop_blk_c  = empty_c;
`else
    assign push_blk_c = 1'b0;
    assign pop_blk_c  = 1'b0;
`endif

    assign push_only_c = push & ~pop;
    assign pop_only_c  = pop & ~push;
    assign replace_c   = push & pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sp_q         <= RESET_SP;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            ack_q        <= ack_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Next state; flags clear first so a same-cycle wrap overrides clr_err.
    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        ack_d        = 1'b0;
        ovf_d        = ovf_q & ~clr_err;
        udf_d        = udf_q & ~clr_err;

        if (load) begin
            sp_d    = din;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (push_only_c) begin
                        addr_d       = sp_q;
                        addr_valid_d = ~push_blk_c;
                        ack_d        = 1'b1;
                        state_d      = ST_BUSY;
                        if (!push_blk_c) sp_d = dec_res_c;
                        if (dec_borrow_c || push_blk_c) ovf_d = 1'b1;
                    end else if (pop_only_c) begin
                        addr_d       = inc_res_c;
                        addr_valid_d = ~pop_blk_c;
                        ack_d        = 1'b1;
                        state_d      = ST_BUSY;
                        if (!pop_blk_c) sp_d = inc_res_c;
                        if (inc_carry_c || pop_blk_c) udf_d = 1'b1;
                    end else if (replace_c) begin
                        addr_d       = inc_res_c;
                        addr_valid_d = 1'b1;
                        ack_d        = 1'b1;
                        state_d      = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A load arriving during the ack cycle cancels the operation, so mask the strobes.
    assign sp         = sp_q;
    assign addr       = addr_q;
    assign addr_valid = addr_valid_q & ~load;
    assign ack        = ack_q & ~load;
    assign empty      = empty_c;
    assign full       = full_c;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Self-checking bench for stack_ptr_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the stack pointer.
module tb_stack_ptr_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, load = 1'b0, clr_err = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] sp, addr;
    logic       addr_valid, ack, empty, full, ovf, udf;

    int checks = 0;
    int errors = 0;

    stack_ptr_unit dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .load(load), .din(din),
        .clr_err(clr_err), .sp(sp), .addr(addr), .addr_valid(addr_valid), .ack(ack),
        .empty(empty), .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

`ifdef STACK_PTR_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL reset_sp got %h exp ff", sp); end
        checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", addr); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
        checks++; if (addr_valid !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", addr_valid, ack); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", ovf, udf); end
        tick();
    endtask

    task automatic test_push_pop();
        push = 1'b1;
        tick();
        push = 1'b0;
        @(negedge clk);
        checks++; if (addr !== 8'hFF || addr_valid !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL push_ack got addr=%h av=%b ack=%b exp ff 1 1", addr, addr_valid, ack); end
        checks++; if (sp !== 8'hFE || empty !== 1'b0) begin errors++; $display("FAIL push_sp got sp=%h empty=%b exp fe 0", sp, empty); end
        tick();
        @(negedge clk);
        checks++; if (ack !== 1'b0 || addr_valid !== 1'b0) begin errors++; $display("FAIL push_ack_pulse got ack=%b av=%b exp 0 0", ack, addr_valid); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        @(negedge clk);
        checks++; if (addr !== 8'hFF || ack !== 1'b1 || addr_valid !== 1'b1) begin errors++; $display("FAIL pop_ack got addr=%h av=%b ack=%b exp ff 1 1", addr, addr_valid, ack); end
        checks++; if (sp !== 8'hFF || empty !== 1'b1) begin errors++; $display("FAIL pop_sp got sp=%h empty=%b exp ff 1", sp, empty); end
        tick();
    endtask

    task automatic test_push_wrap();
        load = 1'b1; din = 8'h00;
        tick();
        load = 1'b0;
        @(negedge clk);
        checks++; if (sp !== 8'h00 || full !== 1'b1) begin errors++; $display("FAIL load_full got sp=%h full=%b exp 00 1", sp, full); end
        push = 1'b1;
        tick();
        push = 1'b0;
        @(negedge clk);
        checks++; if (addr !== 8'h00 || ack !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_push got addr=%h ack=%b ovf=%b exp 00 1 1", addr, ack, ovf); end
        if (LIMIT) begin
            checks++; if (sp !== 8'h00 || addr_valid !== 1'b0) begin errors++; $display("FAIL ovf_block got sp=%h av=%b exp 00 0", sp, addr_valid); end
        end else begin
            checks++; if (sp !== 8'hFF || addr_valid !== 1'b1) begin errors++; $display("FAIL ovf_wrap got sp=%h av=%b exp ff 1", sp, addr_valid); end
        end
        tick();
    endtask

    task automatic test_pop_wrap_clr();
        load = 1'b1; din = 8'hFF;
        tick();
        load = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        @(negedge clk);
        checks++; if (udf !== 1'b1 || addr !== 8'h00 || ack !== 1'b1) begin errors++; $display("FAIL udf_pop got udf=%b addr=%h ack=%b exp 1 00 1", udf, addr, ack); end
        if (LIMIT) begin
            checks++; if (sp !== 8'hFF || addr_valid !== 1'b0) begin errors++; $display("FAIL udf_block got sp=%h av=%b exp ff 0", sp, addr_valid); end
        end else begin
            checks++; if (sp !== 8'h00 || addr_valid !== 1'b1) begin errors++; $display("FAIL udf_wrap got sp=%h av=%b exp 00 1", sp, addr_valid); end
        end
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        checks++; if (udf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL clr_err got ovf=%b udf=%b exp 0 0", ovf, udf); end
        tick();
    endtask

    task automatic test_replace();
        load = 1'b1; din = 8'h80;
        tick();
        load = 1'b0; push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        @(negedge clk);
        checks++; if (addr !== 8'h81 || sp !== 8'h80) begin errors++; $display("FAIL replace got addr=%h sp=%h exp 81 80", addr, sp); end
        checks++; if (ack !== 1'b1 || addr_valid !== 1'b1 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL replace_strobe got ack=%b av=%b ovf=%b udf=%b exp 1 1 0 0", ack, addr_valid, ovf, udf); end
        tick();
    endtask

    task automatic test_load_cancel();
        push = 1'b1;
        tick();
        push = 1'b0; load = 1'b1; din = 8'h40;
        @(negedge clk);
        checks++; if (ack !== 1'b0 || addr_valid !== 1'b0) begin errors++; $display("FAIL cancel_ack got ack=%b av=%b exp 0 0", ack, addr_valid); end
        tick();
        load = 1'b0;
        @(negedge clk);
        checks++; if (sp !== 8'h40 || ack !== 1'b0) begin errors++; $display("FAIL cancel_sp got sp=%h ack=%b exp 40 0", sp, ack); end
        push = 1'b1;
        tick();
        push = 1'b0;
        @(negedge clk);
        checks++; if (ack !== 1'b1 || addr !== 8'h40 || sp !== 8'h3F) begin errors++; $display("FAIL cancel_idle got ack=%b addr=%h sp=%h exp 1 40 3f", ack, addr, sp); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit seen_ack = 1'b0;
        push = 1'b1;
        tick();
        push = 1'b0; rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 1'b0) seen_ack = 1'b1;
            tick();
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack !== 1'b0) seen_ack = 1'b1;
            tick();
        end
        checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL rst_busy_ack got 1 exp 0"); end
        checks++; if (sp !== 8'hFF || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL rst_busy_state got sp=%h ovf=%b udf=%b exp ff 0 0", sp, ovf, udf); end
    endtask

    task automatic test_random();
        int  m_sp = 255, m_addr = 0;
        bit  m_busy = 0, m_av = 0, m_ovf = 0, m_udf = 0;
        bit  blk;
        int  bad = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            push    = ($urandom_range(0, 2) == 0);
            pop     = ($urandom_range(0, 2) == 0);
            load    = ($urandom_range(0, 11) == 0);
            clr_err = ($urandom_range(0, 9) == 0);
            din     = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 1) == 0) ? 0 : 255) : 8'($urandom);
            @(negedge clk);
            checks++;
            if (sp !== 8'(m_sp) || addr !== 8'(m_addr) || ack !== (m_busy && !load) ||
                addr_valid !== (m_busy && m_av && !load) || empty !== (m_sp == 255) ||
                full !== (m_sp == 0) || ovf !== m_ovf || udf !== m_udf) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_%0d got sp=%h addr=%h ack=%b av=%b e=%b f=%b o=%b u=%b exp sp=%h addr=%h ack=%b av=%b o=%b u=%b",
                             n, sp, addr, ack, addr_valid, empty, full, ovf, udf,
                             8'(m_sp), 8'(m_addr), m_busy && !load, m_busy && m_av && !load, m_ovf, m_udf);
                bad++;
            end
            if (clr_err) begin m_ovf = 0; m_udf = 0; end
            if (load) begin
                m_sp = int'(din); m_busy = 0; m_av = 0;
            end else if (m_busy) begin
                m_busy = 0; m_av = 0;
            end else if (push && !pop) begin
                m_addr = m_sp;
                blk = LIMIT && (m_sp == 0);
                if (m_sp == 0) m_ovf = 1;
                if (!blk) m_sp = (m_sp + 255) % 256;
                m_busy = 1; m_av = !blk;
            end else if (pop && !push) begin
                m_addr = (m_sp + 1) % 256;
                blk = LIMIT && (m_sp == 255);
                if (m_sp == 255) m_udf = 1;
                if (!blk) m_sp = (m_sp + 1) % 256;
                m_busy = 1; m_av = !blk;
            end else if (push && pop) begin
                m_addr = (m_sp + 1) % 256;
                m_busy = 1; m_av = 1;
            end
            tick();
        end
        push = 1'b0; pop = 1'b0; load = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_push_wrap();
        test_pop_wrap_clr();
        test_replace();
        test_load_cancel();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
